alarm_unit: RTL and testbench
=============================

# alarm_unit

Epoch alarm comparator downstream of the `timer` stage. It consumes the 64-bit running epoch and raises a level interrupt when the epoch reaches a programmed alarm time. It supports one-shot and periodic alarms, with missed-period counting. The host loads it through the SPI controller's buffer path, and `irq` drives a spare output pin.

## Interface
- `WIDTH`, 64, epoch and alarm width in bits.
- `PERIOD_WIDTH`, 32, repeat-interval width in seconds.
- `MISS_WIDTH`, 8, missed-alarm counter width.

- `clk` in 1: system clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `i_time` in WIDTH: current epoch from `timer` `o_time`.
- `i_alarm` in WIDTH: alarm time to load.
- `i_period` in PERIOD_WIDTH: repeat interval; 0 selects one-shot.
- `alarm_le` in 1: one-cycle strobe that loads `i_alarm` and `i_period`.
- `arm` in 1: one-cycle strobe that arms the alarm.
- `disarm` in 1: one-cycle strobe that cancels the alarm.
- `ack` in 1: one-cycle strobe that acknowledges the interrupt.
- `irq` out 1: interrupt level; high only in state FIRED.
- `o_state` out 2: IDLE=00, ARMED=01, FIRED=10; 11 is unused.
- `o_alarm` out WIDTH: current alarm register, after any advance.
- `o_miss` out MISS_WIDTH: missed-period count, saturating.

## Operation
- **Registers:** `alarm_reg`, `period_reg`, `miss_cnt`, and a 2-bit state.
- **Hit condition:** `hit` = (`i_time` >= `alarm_reg`), unsigned and combinational. Use ">=" rather than "==", so an epoch loaded past the alarm time still fires.
- **Priority** of events in a single cycle, highest first: `rst`, `disarm`, `alarm_le`, `ack`, `hit`, `arm`.
- **`disarm`** (any state) -> IDLE. `irq` drops; registers are kept.
- **`alarm_le`** (any state): `alarm_reg`<=`i_alarm`, `period_reg`<=`i_period`, state -> IDLE, `miss_cnt`<=0. Software must re-arm afterwards.
- **IDLE:**
  - `arm` -> ARMED, `miss_cnt`<=0.
  - `hit` is ignored.
  - `ack` is ignored.
- **ARMED:**
  - `hit` -> FIRED.
  - If `period_reg`!=0, `alarm_reg` <= `alarm_reg`+`period_reg` in the same cycle.
  - `arm` in ARMED is a no-op.
- **FIRED:**
  - `ack` -> ARMED if `period_reg`!=0, else -> IDLE.
  - Without `ack`, if `hit` (against the advanced `alarm_reg`) and `period_reg`!=0:
    - `miss_cnt` increments, saturating at all-ones.
    - `alarm_reg` advances by `period_reg` again.
    - State stays FIRED.
  - A one-shot alarm in FIRED ignores `hit`.
- **Catch-up:** if `i_time` is far ahead, the unit advances once per cycle until `hit` clears. Each advance while in FIRED counts as a miss.
- **Width and wrap:**
  - Advance is `alarm_reg` + zero-extended `period_reg`, computed WIDTH+1 bits wide.
  - On carry-out, `alarm_reg` takes the truncated sum, and `period_reg` is cleared so the alarm degrades to one-shot. This prevents endless re-hits after a wrap.
- `ack` together with `hit` in FIRED: `ack` wins. The transition follows the `ack` rule, no miss is counted, and no advance happens in that cycle. A still-true `hit` is evaluated from ARMED on the next cycle.

## Timing
- **Reset values:** `irq`=0, `o_state`=00, `o_alarm`=all-ones (never hits unless `i_time` is all-ones), `o_miss`=0, `period_reg`=0.
- **Hit latency:** `i_time` satisfying `hit` in cycle N while ARMED gives `irq`=1, `o_state`=10 and the advanced `o_alarm` in cycle N+1.
- **`ack` latency:** `ack` in cycle N gives `irq`=0 in cycle N+1.
- **`alarm_le`, `arm`, `disarm` latency:** one cycle to visible state.
- All outputs are registered; there is no combinational input-to-output path.
- Reset mid-FIRED clears `irq` in the next cycle; no pending state survives reset.
- Strobes held for multiple cycles act once per cycle. Repeated `arm` or `ack` is idempotent per the state rules.

## Test plan
- **One-shot:**
  - Stimulus: load alarm=100, period=0, arm, then step `i_time` 98->99->100.
  - Required: `irq` rises the cycle after 100 is presented; `o_state`=10; `o_alarm`=100.
  - Then `ack`: `irq`=0 and state IDLE the next cycle.
- **Periodic:**
  - Stimulus: load alarm=10, period=5, arm, step time to 10, then `ack`, then step time to 15.
  - Required: `o_alarm`=15 after the first fire, fire again at 15, `o_alarm`=20; `o_miss`=0.
- **Missed periods:**
  - Stimulus: load alarm=10, period=5, arm, jump `i_time` to 27 and hold with no `ack`.
  - Required: `o_alarm` steps 15, 20, 25, 30 on consecutive cycles, then holds at 30; `o_miss`=3; `irq` stays 1.
- **Late load:**
  - Stimulus: `i_time`=500, load alarm=400 one-shot, arm.
  - Required: `irq` asserts one cycle after `arm` takes effect.
- **Wrap:**
  - Stimulus: load alarm=2^64-3, period=8, arm, set `i_time`=2^64-3.
  - Required: fire; `o_alarm`=5; period cleared. After `ack`, state IDLE; no further fire at `i_time`=2^64-1.
- **Priority and reset:**
  - Stimulus A: `disarm` and `hit` in the same cycle while ARMED. Required: IDLE, `irq`=0.
  - Stimulus B: `alarm_le` while FIRED. Required: IDLE, new alarm loaded, `o_miss`=0.
  - Stimulus C: `rst` while FIRED. Required: all outputs at reset values next cycle.

Source files
------------

// File: rtl/alarm_unit_if.sv
// Host-side bundle for alarm_unit: epoch input, alarm load/control strobes,
// and the registered interrupt/status outputs.
interface alarm_unit_if #(
    parameter int WIDTH        = 64,
    parameter int PERIOD_WIDTH = 32,
    parameter int MISS_WIDTH   = 8
);
    logic [WIDTH-1:0]        i_time;
    logic [WIDTH-1:0]        i_alarm;
    logic [PERIOD_WIDTH-1:0] i_period;
    logic                    alarm_le;
    logic                    arm;
    logic                    disarm;
    logic                    ack;
    logic                    irq;
    logic [1:0]              o_state;
    logic [WIDTH-1:0]        o_alarm;
    logic [MISS_WIDTH-1:0]   o_miss;

    modport master (
        output i_time, i_alarm, i_period, alarm_le, arm, disarm, ack,
        input  irq, o_state, o_alarm, o_miss
    );

    modport slave (
        input  i_time, i_alarm, i_period, alarm_le, arm, disarm, ack,
        output irq, o_state, o_alarm, o_miss
    );
endinterface

// File: rtl/alarm_unit.sv
// Epoch alarm comparator: one-shot or periodic alarm with level irq and
// saturating missed-period count; advances degrade to one-shot on wrap.
module alarm_unit #(
    parameter int WIDTH        = 64,
    parameter int PERIOD_WIDTH = 32,
    parameter int MISS_WIDTH   = 8
) (
    input  logic         clk,
    input  logic         rst,
    alarm_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_FIRED = 2'b10
    } state_e;

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        alarm_q, alarm_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [MISS_WIDTH-1:0]   miss_q, miss_d;
    logic                    irq_q, irq_d;

    logic                    hit_s;
    logic                    periodic_s;
    logic [WIDTH:0]          sum_s;
    logic [WIDTH-1:0]        adv_alarm_s;
    logic [PERIOD_WIDTH-1:0] adv_period_s;
    logic [MISS_WIDTH-1:0]   miss_inc_s;

    // Hit test and the one-step advance candidate (carry-out drops the period)
    always_comb begin
        hit_s        = (bus.i_time >= alarm_q);
        periodic_s   = (period_q != {PERIOD_WIDTH{1'b0}});
        sum_s        = {1'b0, alarm_q} + {{(WIDTH + 1 - PERIOD_WIDTH){1'b0}}, period_q};
        adv_alarm_s  = sum_s[WIDTH-1:0];
        adv_period_s = sum_s[WIDTH] ? {PERIOD_WIDTH{1'b0}} : period_q;
        miss_inc_s   = (&miss_q) ? miss_q : (miss_q + {{(MISS_WIDTH-1){1'b0}}, 1'b1});
    end

    // Next-state logic in priority order: disarm, alarm_le, then per-state rules
    always_comb begin
        state_d  = state_q;
        alarm_d  = alarm_q;
        period_d = period_q;
        miss_d   = miss_q;
        if (bus.disarm) begin
            state_d = ST_IDLE;
        end else if (bus.alarm_le) begin
            alarm_d  = bus.i_alarm;
            period_d = bus.i_period;
            miss_d   = {MISS_WIDTH{1'b0}};
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.arm) begin
                        state_d = ST_ARMED;
                        miss_d  = {MISS_WIDTH{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (hit_s) begin
                        state_d = ST_FIRED;
                        if (periodic_s) begin
                            alarm_d  = adv_alarm_s;
                            period_d = adv_period_s;
                        end else begin
                            alarm_d = alarm_q;
                        end
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_FIRED: begin
                    // ack beats a concurrent hit; no advance or miss that cycle
                    if (bus.ack) begin
                        state_d = periodic_s ? ST_ARMED : ST_IDLE;
                    end else if (hit_s && periodic_s) begin
                        alarm_d  = adv_alarm_s;
                        period_d = adv_period_s;
                        miss_d   = miss_inc_s;
                    end else begin
                        state_d = ST_FIRED;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        irq_d = (state_d == ST_FIRED);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            alarm_q  <= {WIDTH{1'b1}};
            period_q <= {PERIOD_WIDTH{1'b0}};
            miss_q   <= {MISS_WIDTH{1'b0}};
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            alarm_q  <= alarm_d;
            period_q <= period_d;
            miss_q   <= miss_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.irq     = irq_q;
    assign bus.o_state = state_q;
    assign bus.o_alarm = alarm_q;
    assign bus.o_miss  = miss_q;
endmodule

// File: tb/tb_alarm_unit.sv
// Scoreboard bench for alarm_unit: directed scenarios plus random strobes,
// checked against a behavioural model of the alarm rules.
module tb_alarm_unit;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic        irq;
        logic [1:0]  st;
        logic [63:0] al;
        logic [7:0]  miss;
    } exp_t;

    logic clk;
    logic rst;
    alarm_unit_if #(.WIDTH(64), .PERIOD_WIDTH(32), .MISS_WIDTH(8)) bus ();

    alarm_unit #(.WIDTH(64), .PERIOD_WIDTH(32), .MISS_WIDTH(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    // behavioural model: 0 idle, 1 armed, 2 fired
    int          m_st;
    logic [63:0] m_alarm;
    logic [31:0] m_period;
    int          m_miss;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void m_advance();
        logic [63:0] nxt;
        nxt = m_alarm + 64'(m_period);
        if (nxt < m_alarm) m_period = 32'd0;
        m_alarm = nxt;
    endfunction

    function automatic void model_step();
        logic hit;
        hit = (bus.i_time >= m_alarm);
        if (rst) begin
            m_st = 0; m_alarm = ALL1; m_period = 32'd0; m_miss = 0;
        end else if (bus.disarm) begin
            m_st = 0;
        end else if (bus.alarm_le) begin
            m_alarm = bus.i_alarm; m_period = bus.i_period; m_miss = 0; m_st = 0;
        end else if (m_st == 0) begin
            if (bus.arm) begin m_st = 1; m_miss = 0; end
        end else if (m_st == 1) begin
            if (hit) begin
                m_st = 2;
                if (m_period != 32'd0) m_advance();
            end
        end else begin
            if (bus.ack) m_st = (m_period != 32'd0) ? 1 : 0;
            else if (hit && m_period != 32'd0) begin
                if (m_miss < 255) m_miss = m_miss + 1;
                m_advance();
            end
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // One clock cycle: inputs already on the bus, record expectation, then clear strobes
    task automatic tick();
        exp_t e;
        model_step();
        e.irq = (m_st == 2); e.st = 2'(m_st); e.al = m_alarm; e.miss = 8'(m_miss);
        exp_q.push_back(e);
        @(negedge clk);
        rst = 1'b0;
        bus.alarm_le = 1'b0; bus.arm = 1'b0; bus.disarm = 1'b0; bus.ack = 1'b0;
    endtask

    task automatic load(input logic [63:0] a, input logic [31:0] p);
        bus.i_alarm = a; bus.i_period = p; bus.alarm_le = 1'b1; tick();
    endtask

    // Monitor: outputs are presented every cycle, compare each against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_irq",   64'(bus.irq),     64'(e.irq));
                chk("sb_state", 64'(bus.o_state), 64'(e.st));
                chk("sb_alarm", bus.o_alarm,      e.al);
                chk("sb_miss",  64'(bus.o_miss),  64'(e.miss));
            end
        end
    end

    initial begin
        logic [63:0] t;
        rst = 1'b1;
        bus.i_time = 64'd0; bus.i_alarm = 64'd0; bus.i_period = 32'd0;
        bus.alarm_le = 1'b0; bus.arm = 1'b0; bus.disarm = 1'b0; bus.ack = 1'b0;
        @(negedge clk);
        rst = 1'b1; tick();
        chk("reset_state", 64'(bus.o_state), 64'd0);
        chk("reset_alarm", bus.o_alarm, ALL1);

        // one-shot
        bus.i_time = 64'd98; load(64'd100, 32'd0);
        bus.arm = 1'b1; tick();
        tick();
        bus.i_time = 64'd99; tick();
        chk("oneshot_early", 64'(bus.irq), 64'd0);
        bus.i_time = 64'd100; tick();
        chk("oneshot_irq", 64'(bus.irq), 64'd1);
        chk("oneshot_alarm", bus.o_alarm, 64'd100);
        bus.ack = 1'b1; tick();
        chk("oneshot_ack_state", 64'(bus.o_state), 64'd0);

        // periodic
        bus.i_time = 64'd0; load(64'd10, 32'd5);
        bus.arm = 1'b1; tick();
        bus.i_time = 64'd10; tick();
        chk("periodic_alarm1", bus.o_alarm, 64'd15);
        bus.ack = 1'b1; tick();
        chk("periodic_ack_state", 64'(bus.o_state), 64'd1);
        bus.i_time = 64'd15; tick();
        chk("periodic_alarm2", bus.o_alarm, 64'd20);
        chk("periodic_miss", 64'(bus.o_miss), 64'd0);
        bus.ack = 1'b1; tick();

        // missed periods, then alarm_le while FIRED
        bus.i_time = 64'd0; load(64'd10, 32'd5);
        bus.arm = 1'b1; tick();
        bus.i_time = 64'd27;
        repeat (6) tick();
        chk("miss_alarm", bus.o_alarm, 64'd30);
        chk("miss_count", 64'(bus.o_miss), 64'd3);
        chk("miss_irq", 64'(bus.irq), 64'd1);
        load(64'd1000, 32'd0);
        chk("le_fired_state", 64'(bus.o_state), 64'd0);
        chk("le_fired_miss", 64'(bus.o_miss), 64'd0);

        // late load
        bus.i_time = 64'd500; load(64'd400, 32'd0);
        bus.arm = 1'b1; tick();
        tick();
        chk("late_irq", 64'(bus.irq), 64'd1);

        // disarm beats hit
        bus.i_time = 64'd0; load(64'd50, 32'd0);
        bus.arm = 1'b1; tick();
        bus.i_time = 64'd60; bus.disarm = 1'b1; tick();
        chk("disarm_irq", 64'(bus.irq), 64'd0);
        chk("disarm_state", 64'(bus.o_state), 64'd0);

        // wrap
        bus.i_time = 64'd0; load(ALL1 - 64'd2, 32'd8);
        bus.arm = 1'b1; tick();
        bus.i_time = ALL1 - 64'd2; tick(); tick();
        chk("wrap_alarm", bus.o_alarm, 64'd5);
        chk("wrap_irq", 64'(bus.irq), 64'd1);
        bus.ack = 1'b1; tick();
        bus.i_time = ALL1; tick(); tick();
        chk("wrap_ack_state", 64'(bus.o_state), 64'd0);

        // reset while FIRED
        bus.i_time = 64'd0; load(64'd10, 32'd5);
        bus.arm = 1'b1; tick();
        bus.i_time = 64'd10; tick();
        rst = 1'b1; tick();
        chk("rst_irq", 64'(bus.irq), 64'd0);
        chk("rst_alarm", bus.o_alarm, ALL1);

        // random phase
        t = 64'd0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) t = ALL1 - 64'd40;
            else if ($urandom_range(0, 49) == 0) t = t + 64'd30;
            else t = t + 64'($urandom_range(0, 3));
            bus.i_time = t;
            rst          = ($urandom_range(0, 199) == 0);
            bus.alarm_le = ($urandom_range(0, 39) == 0);
            bus.arm      = ($urandom_range(0, 5) == 0);
            bus.disarm   = ($urandom_range(0, 59) == 0);
            bus.ack      = ($urandom_range(0, 9) == 0);
            bus.i_alarm  = t + 64'($urandom_range(0, 20));
            case ($urandom_range(0, 3))
                0:       bus.i_period = 32'd0;
                3:       bus.i_period = $urandom;
                default: bus.i_period = 32'($urandom_range(1, 8));
            endcase
            tick();
        end

        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
